psum_accumulator: RTL

//  Read-modify-write engine in front of the dual-address psum sram (separate A_rd/A_wr, 1-cycle read).

---
 rtl/psum_accumulator_if.sv | 30 +++
 rtl/psum_accumulator.sv | 91 +++++++++
 2 files changed

// File: rtl/psum_accumulator_if.sv
// Stream-side and sram-side signals of the psum read-modify-write engine.
// The slave view is the accumulator; the master view is the upstream drain plus the sram.
interface psum_accumulator_if #(
  parameter int col     = 8,
  parameter int psum_bw = 16,
  parameter int aw      = 11
);
  logic                     in_valid;
  logic                     in_first;
  logic [aw-1:0]            in_addr;
  logic [col*psum_bw-1:0]   in_psum;

  logic                     sram_CEN;
  logic                     sram_REN;
  logic                     sram_WEN;
  logic [aw-1:0]            sram_A_rd;
  logic [aw-1:0]            sram_A_wr;
  logic [col*psum_bw-1:0]   sram_D;
  logic [col*psum_bw-1:0]   sram_Q;

  modport master (
    output in_valid, in_first, in_addr, in_psum, sram_Q,
    input  sram_CEN, sram_REN, sram_WEN, sram_A_rd, sram_A_wr, sram_D
  );

  modport slave (
    input  in_valid, in_first, in_addr, in_psum, sram_Q,
    output sram_CEN, sram_REN, sram_WEN, sram_A_rd, sram_A_wr, sram_D
  );
endinterface

// File: rtl/psum_accumulator.sv
// Two-stage read-modify-write engine: issue the sram read in S0, add and write back from S1.
// Same-address back-to-back vectors bypass the sram through the previous cycle's write data.
module psum_accumulator #(
  parameter int col     = 8,
  parameter int psum_bw = 16,
  parameter int num     = 2048
) (
  input  logic                CLK,
  input  logic                reset_n,
  psum_accumulator_if.slave   bus,
  output logic                busy,
  output logic [15:0]         wr_cnt
);
  localparam int aw = $clog2(num);
  localparam int vw = col * psum_bw;
  localparam logic [psum_bw-1:0] lane_max = {1'b0, {(psum_bw-1){1'b1}}};
  localparam logic [psum_bw-1:0] lane_min = {1'b1, {(psum_bw-1){1'b0}}};

  logic               s1_valid_q, s1_first_q, s1_fwd_q;
  logic [aw-1:0]      s1_addr_q, a_rd_q, a_rd_d;
  logic [vw-1:0]      s1_psum_q, last_d_q;
  logic [vw-1:0]      base, sat_sum, d_out;
  logic [15:0]        wr_cnt_q;
  logic               fwd, rd_req;
  logic [psum_bw:0]   lane_sum [col];

  // A read issued against the address being written this cycle would be
  // dropped by the sram and return stale data, so forward instead.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned and infers a latch.
    fwd    = s1_valid_q && (bus.in_addr == s1_addr_q);
    rd_req = reset_n && bus.in_valid && !bus.in_first && !fwd;
    a_rd_d = a_rd_q;
    if (rd_req) a_rd_d = bus.in_addr;
  end

  // Per-lane signed add with one guard bit; disagreeing top bits mean overflow.
  always_comb begin
    base     = s1_fwd_q ? last_d_q : bus.sram_Q;
    sat_sum  = '0;
    lane_sum = '{default: '0};
    for (int k = 0; k < col; k++) begin
      lane_sum[k] = {s1_psum_q[k*psum_bw+psum_bw-1], s1_psum_q[k*psum_bw +: psum_bw]}
                  + {base[k*psum_bw+psum_bw-1],      base[k*psum_bw +: psum_bw]};
      if (lane_sum[k][psum_bw] != lane_sum[k][psum_bw-1])
        sat_sum[k*psum_bw +: psum_bw] = lane_sum[k][psum_bw] ? lane_min : lane_max;
      else
        sat_sum[k*psum_bw +: psum_bw] = lane_sum[k][psum_bw-1:0];
    end
  end

  always_comb begin
    d_out = '0;
    if (s1_valid_q) d_out = s1_first_q ? s1_psum_q : sat_sum;
  end

  assign bus.sram_REN  = ~rd_req;
  assign bus.sram_WEN  = ~s1_valid_q;
  assign bus.sram_CEN  = bus.sram_REN & bus.sram_WEN;
  assign bus.sram_A_rd = a_rd_d;
  assign bus.sram_A_wr = s1_addr_q;
  assign bus.sram_D    = d_out;
  assign busy          = s1_valid_q;
  assign wr_cnt        = wr_cnt_q;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge CLK or negedge reset_n) begin
    if (!reset_n) begin
      s1_valid_q <= 1'b0;
      s1_first_q <= 1'b0;
      s1_fwd_q   <= 1'b0;
      s1_addr_q  <= '0;
      a_rd_q     <= '0;
      last_d_q   <= '0;
      wr_cnt_q   <= '0;
    end else begin
      s1_valid_q <= bus.in_valid;
      s1_first_q <= bus.in_first;
      s1_fwd_q   <= fwd;
      s1_addr_q  <= bus.in_addr;
      a_rd_q     <= a_rd_d;
      last_d_q   <= d_out;
      wr_cnt_q   <= wr_cnt_q + 16'(s1_valid_q);
    end
  end

  // NOTE: pure datapath payload is left unreset; it is only observed when s1_valid_q is set.
  always_ff @(posedge CLK) begin
    s1_psum_q <= bus.in_psum;
  end
endmodule
